// File: rtl/regfile_wb_sched_pkg.sv
// Shared types and constants for the Y86-64 register-file write-back scheduler.
// Register IDs, data words, queued write ops and scheduler FSM states.
package regfile_wb_sched_pkg;

  localparam int REG_W  = 4;
  localparam int WORD_W = 64;
  localparam int NREG   = 15;

  typedef logic [REG_W-1:0]  regId_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam regId_t RNONE    = 4'hf;
  localparam regId_t LAST_REG = regId_t'(NREG - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } schedState_t;

  typedef struct packed {
    regId_t addr;
    word_t  data;
  } wbOp_t;

  function automatic logic isReg(regId_t id);
    return id != RNONE;
  endfunction

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Retiring-instruction handshake into the write-back scheduler.
// Upstream drives the master side; the scheduler is the slave.
interface regfile_wb_sched_if
  import regfile_wb_sched_pkg::*;
  ;

  logic   wb_valid;
  logic   wb_ready;
  regId_t wb_dstE;
  word_t  wb_valE;
  regId_t wb_dstM;
  word_t  wb_valM;

  modport master (
    output wb_valid,
    output wb_dstE,
    output wb_valE,
    output wb_dstM,
    output wb_valM,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_dstE,
    input  wb_valE,
    input  wb_dstM,
    input  wb_valM,
    output wb_ready
  );

endinterface

// File: rtl/regfile_wb_sched_fifo.sv
// Circular queue of pending register writes, up to two pushes per cycle.
// Entries are exported oldest-first so the forward search can rank by age.
module regfile_wb_sched_fifo
  import regfile_wb_sched_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push0,
  input  wbOp_t                   push0Op,
  input  logic                    push1,
  input  wbOp_t                   push1Op,
  input  logic                    pop,
  output logic [CW-1:0]           count,
  output logic [DEPTH-1:0]        entValid,
  output wbOp_t [DEPTH-1:0]       entOp
);

  wbOp_t          mem [DEPTH];
  logic [PW-1:0]  rdPtr;
  logic [PW-1:0]  wrPtr;
  logic [1:0]     nPush;

  assign nPush = {1'b0, push0} + {1'b0, push1};

  // push1 is only ever asserted together with push0
  always_ff @(posedge clk) begin
    if (push0) mem[wrPtr] <= push0Op;
    if (push1) mem[wrPtr + PW'(1)] <= push1Op;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + PW'(nPush);
      if (pop) rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(nPush) - CW'(pop);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : gAge
    assign entOp[k]    = mem[rdPtr + PW'(k)];
    assign entValid[k] = CW'(k) < count;
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: INIT loads the register file, then RUN queues
// retiring E/M writes, issues one per cycle and forwards pending values.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter bit INIT_SEQ = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_sched_if.slave    wb,
  output logic                 rf_we,
  output regId_t               rf_waddr,
  output word_t                rf_wdata,
  input  regId_t               srcA,
  input  regId_t               srcB,
  output logic                 fwdA_hit,
  output word_t                fwdA_data,
  output logic                 fwdB_hit,
  output word_t                fwdB_data,
  output logic                 busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  schedState_t        state;
  schedState_t        stateNext;
  regId_t             icnt;

  logic [CW-1:0]      count;
  logic [DEPTH-1:0]   entValid;
  wbOp_t [DEPTH-1:0]  entOp;

  logic   accept;
  logic   eLive;
  logic   mLive;
  logic   push0;
  logic   push1;
  logic   pop;
  wbOp_t  opE;
  wbOp_t  opM;
  wbOp_t  push0Op;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INIT;
      icnt  <= '0;
    end else begin
      state <= stateNext;
      if (state == ST_INIT) icnt <= icnt + 4'd1;
    end
  end

  always_comb begin
    stateNext   = state;
    wb.wb_ready = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    pop         = 1'b0;
    unique case (state)
      ST_INIT: begin
        rf_we    = 1'b1;
        rf_waddr = icnt;
        rf_wdata = INIT_SEQ ? word_t'(icnt) : '0;
        if (icnt == LAST_REG) stateNext = ST_RUN;
      end
      ST_RUN: begin
        wb.wb_ready = count <= READY_MAX;
        if (count != '0) begin
          rf_we    = 1'b1;
          rf_waddr = entOp[0].addr;
          rf_wdata = entOp[0].data;
          pop      = 1'b1;
        end
      end
      default: stateNext = ST_INIT;
    endcase
  end

  // E is dropped when M targets the same register: M wins
  assign accept  = wb.wb_valid & wb.wb_ready;
  assign mLive   = isReg(wb.wb_dstM);
  assign eLive   = isReg(wb.wb_dstE) &&
                   (wb.wb_dstE != wb.wb_dstM);
  assign opE     = '{addr: wb.wb_dstE, data: wb.wb_valE};
  assign opM     = '{addr: wb.wb_dstM, data: wb.wb_valM};
  assign push0   = accept & (eLive | mLive);
  assign push0Op = eLive ? opE : opM;
  assign push1   = accept & eLive & mLive;

  regfile_wb_sched_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push0    (push0),
    .push0Op  (push0Op),
    .push1    (push1),
    .push1Op  (opM),
    .pop      (pop),
    .count    (count),
    .entValid (entValid),
    .entOp    (entOp)
  );

  // later (younger) matches overwrite earlier ones
  always_comb begin
    fwdA_hit  = 1'b0;
    fwdA_data = '0;
    fwdB_hit  = 1'b0;
    fwdB_data = '0;
    if (state == ST_RUN) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (entValid[k] && isReg(srcA) &&
            entOp[k].addr == srcA) begin
          fwdA_hit  = 1'b1;
          fwdA_data = entOp[k].data;
        end
        if (entValid[k] && isReg(srcB) &&
            entOp[k].addr == srcB) begin
          fwdB_hit  = 1'b1;
          fwdB_data = entOp[k].data;
        end
      end
    end
  end

  assign busy = (state == ST_INIT) | (count != '0);

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_regfile_wb_sched;
  import regfile_wb_sched_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_sched_if wbBus ();

  logic   rf_we;
  regId_t rf_waddr;
  word_t  rf_wdata;
  regId_t srcA;
  regId_t srcB;
  logic   fwdA_hit;
  word_t  fwdA_data;
  logic   fwdB_hit;
  word_t  fwdB_data;
  logic   busy;

  regfile_wb_sched #(
    .DEPTH    (DEPTH),
    .INIT_SEQ (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (wbBus),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .srcA      (srcA),
    .srcB      (srcB),
    .fwdA_hit  (fwdA_hit),
    .fwdA_data (fwdA_data),
    .fwdB_hit  (fwdB_hit),
    .fwdB_data (fwdB_data),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  typedef struct {
    regId_t a;
    word_t  d;
  } op_t;

  op_t q[$];
  bit  mOn = 1'b0;
  bit  mInit;
  int  mIcnt;

  logic   eWe, eRdy, eHa, eHb, eBusy;
  regId_t eAddr;
  word_t  eData, eDa, eDb;

  function automatic void look(input regId_t s,
                               output logic h,
                               output word_t d);
    h = 1'b0;
    d = '0;
    if (s != RNONE)
      for (int i = 0; i < q.size(); i++)
        if (q[i].a == s) begin
          h = 1'b1;
          d = q[i].d;
        end
  endfunction

  // Inputs are stable from posedge+1 to the next posedge, so the model
  // compares here and then advances using what the next edge will see.
  always @(negedge clk) begin
    if (mOn) begin
      if (mInit) begin
        eWe = 1'b1; eAddr = regId_t'(mIcnt);
        eData = word_t'(mIcnt); eRdy = 1'b0;
        eHa = 1'b0; eDa = '0; eHb = 1'b0; eDb = '0;
        eBusy = 1'b1;
      end else begin
        eRdy  = q.size() <= DEPTH - 2;
        eWe   = q.size() > 0;
        eAddr = eWe ? q[0].a : '0;
        eData = eWe ? q[0].d : '0;
        look(srcA, eHa, eDa);
        look(srcB, eHb, eDb);
        eBusy = q.size() != 0;
      end
      chk("m_we", rf_we, eWe);
      chk("m_waddr", rf_waddr, eAddr);
      chk("m_wdata", rf_wdata, eData);
      chk("m_ready", wbBus.wb_ready, eRdy);
      chk("m_fwdA_hit", fwdA_hit, eHa);
      chk("m_fwdA_data", fwdA_data, eDa);
      chk("m_fwdB_hit", fwdB_hit, eHb);
      chk("m_fwdB_data", fwdB_data, eDb);
      chk("m_busy", busy, eBusy);
    end
    if (!rst_n) begin
      mOn = 1'b1; mInit = 1'b1; mIcnt = 0;
      q.delete();
    end else if (mOn) begin
      if (mInit) begin
        if (mIcnt == NREG - 1) mInit = 1'b0;
        mIcnt++;
      end else begin
        bit rdy;
        rdy = q.size() <= DEPTH - 2;
        if (q.size() > 0) void'(q.pop_front());
        if (wbBus.wb_valid && rdy) begin
          if (wbBus.wb_dstE != RNONE &&
              wbBus.wb_dstE != wbBus.wb_dstM)
            q.push_back('{wbBus.wb_dstE, wbBus.wb_valE});
          if (wbBus.wb_dstM != RNONE)
            q.push_back('{wbBus.wb_dstM, wbBus.wb_valM});
        end
      end
    end
  end

  task automatic drive(input logic v,
                       input regId_t de, input word_t ve,
                       input regId_t dm, input word_t vm);
    @(posedge clk);
    #1;
    wbBus.wb_valid = v;
    wbBus.wb_dstE  = de;
    wbBus.wb_valE  = ve;
    wbBus.wb_dstM  = dm;
    wbBus.wb_valM  = vm;
  endtask

  function automatic regId_t rndDst();
    if ($urandom_range(4) == 0) return RNONE;
    return regId_t'($urandom_range(14));
  endfunction

  task automatic checkInit(input string tag);
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      chk({tag, "_we"}, rf_we, 1);
      chk({tag, "_addr"}, rf_waddr, i);
      chk({tag, "_data"}, rf_wdata, i);
      chk({tag, "_rdy"}, wbBus.wb_ready, 0);
    end
    @(negedge clk);
    chk({tag, "_done_we"}, rf_we, 0);
    chk({tag, "_done_busy"}, busy, 0);
    chk({tag, "_done_rdy"}, wbBus.wb_ready, 1);
  endtask

  initial begin
    logic   rdy, v;
    regId_t de, dm;
    word_t  ve, vm;
    wbBus.wb_valid = 1'b0;
    wbBus.wb_dstE = RNONE; wbBus.wb_valE = '0;
    wbBus.wb_dstM = RNONE; wbBus.wb_valM = '0;
    srcA = RNONE; srcB = RNONE;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkInit("init");

    drive(1, 3, 64'hAA, RNONE, 0);
    drive(0, RNONE, 0, RNONE, 0);
    @(negedge clk);
    chk("t2_we", rf_we, 1);
    chk("t2_addr", rf_waddr, 3);
    chk("t2_data", rf_wdata, 64'hAA);
    @(negedge clk);
    chk("t2_idle_we", rf_we, 0);

    drive(1, 4, 64'h11, 4, 64'h22);
    drive(0, RNONE, 0, RNONE, 0);
    @(negedge clk);
    chk("t3_we", rf_we, 1);
    chk("t3_addr", rf_waddr, 4);
    chk("t3_data", rf_wdata, 64'h22);
    @(negedge clk);
    chk("t3_idle_we", rf_we, 0);

    srcA = 5;
    drive(1, 7, 64'h33, 5, 64'h1);
    drive(1, 5, 64'h2, RNONE, 0);
    drive(0, RNONE, 0, RNONE, 0);
    @(negedge clk);
    chk("t5_head_addr", rf_waddr, 5);
    chk("t5_head_data", rf_wdata, 64'h1);
    chk("t5_hitA", fwdA_hit, 1);
    chk("t5_dataA", fwdA_data, 64'h2);
    chk("t5_hitB", fwdB_hit, 0);
    @(negedge clk);
    chk("t5_hitA_1", fwdA_hit, 1);
    chk("t5_dataA_1", fwdA_data, 64'h2);
    @(negedge clk);
    chk("t5_hitA_0", fwdA_hit, 0);
    srcA = RNONE;

    // Saturation, then random traffic; fields held while not accepted.
    v = 1'b0; de = RNONE; dm = RNONE; ve = '0; vm = '0;
    for (int k = 0; k < 2040; k++) begin
      @(negedge clk);
      rdy = wbBus.wb_ready;
      @(posedge clk);
      #1;
      if (k >= 40) begin
        rst_n = ($urandom_range(299) != 0);
        srcA = regId_t'($urandom_range(15));
        srcB = regId_t'($urandom_range(15));
      end else begin
        srcA = regId_t'(k % 8);
        srcB = regId_t'(7 + k % 8);
      end
      if (!v || rdy) begin
        if (k < 40) begin
          v = 1'b1;
          de = regId_t'(k % 7);
          dm = regId_t'(7 + k % 7);
        end else begin
          v = ($urandom_range(3) != 0);
          de = rndDst();
          dm = ($urandom_range(5) == 0) ? de : rndDst();
        end
        ve = {$urandom, $urandom};
        vm = {$urandom, $urandom};
      end
      wbBus.wb_valid = v;
      wbBus.wb_dstE = de; wbBus.wb_valE = ve;
      wbBus.wb_dstM = dm; wbBus.wb_valM = vm;
    end

    drive(0, RNONE, 0, RNONE, 0);
    rst_n = 1'b1;
    srcA = RNONE; srcB = RNONE;
    repeat (20) @(posedge clk);

    drive(1, 1, 64'hDEAD1, 2, 64'hDEAD2);
    drive(1, 3, 64'hDEAD3, 4, 64'hDEAD4);
    drive(0, RNONE, 0, RNONE, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 1);
    chk("t6_head_addr", rf_waddr, 2);
    chk("t6_head_data", rf_wdata, 64'hDEAD2);
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkInit("t6");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
